// File: rtl/vx_lsu_pkg.sv
// -----------------------------------------------------------------------------
// vx_lsu_pkg
// Shared types for the LSU request path.
//   lsu_req_t        : flattened LSU request payload (128 bits)
//   LSU_REQ_DATAW    : width of lsu_req_t
//   lsu_skid_entry_t : one slot of the arbiter's output skid buffer
// -----------------------------------------------------------------------------
package vx_lsu_pkg;

    typedef struct packed {
        logic [15:0] uuid;
        logic [3:0]  wid;
        logic [3:0]  tmask;
        logic [31:0] pc;
        logic [3:0]  op_type;
        logic [31:0] store_data;
        logic [19:0] base_addr;
        logic [7:0]  offset;
        logic [5:0]  rd;
        logic        wb;
        logic        is_prefetch;
    } lsu_req_t;

    localparam int unsigned LSU_REQ_DATAW = $bits(lsu_req_t);

    // Wide enough for any realistic channel count; the top uses the low SELW bits.
    localparam int unsigned LSU_SEL_MAXW = 8;

    typedef struct packed {
        lsu_req_t                  req;
        logic                      fence;
        logic [LSU_SEL_MAXW-1:0]   sel;
    } lsu_skid_entry_t;

endpackage

// File: rtl/vx_rr_arbiter.sv
// -----------------------------------------------------------------------------
// vx_rr_arbiter
// Round-robin arbiter; the search starts at the pointer and the pointer only
// advances (to winner+1) when the caller reports the grant was accepted.
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset (pointer -> 0)
//   req_i              : per-requester request
//   accept_i           : current grant was taken this cycle
//   grant_valid_o      : some requester is granted
//   grant_idx_o        : index of granted requester
//   grant_oh_o         : one-hot grant
// -----------------------------------------------------------------------------
module vx_rr_arbiter #(
    parameter int unsigned NUM_REQS = 4,
    localparam int unsigned SELW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_REQS-1:0] req_i,
    input  logic                accept_i,
    output logic                grant_valid_o,
    output logic [SELW-1:0]     grant_idx_o,
    output logic [NUM_REQS-1:0] grant_oh_o
);

    localparam int unsigned IW = SELW + 1;

    logic [SELW-1:0] ptr_q, ptr_d;
    logic [IW-1:0]   sum;
    logic [SELW-1:0] idx;

    // Scan ptr, ptr+1, ... with wrap; first hit wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        grant_oh_o    = '0;
        sum           = '0;
        idx           = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            sum = {1'b0, ptr_q} + IW'(i);
            if (sum >= IW'(NUM_REQS)) begin
                sum = sum - IW'(NUM_REQS);
            end
            idx = SELW'(sum);
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o   = 1'b1;
                grant_idx_o     = idx;
                grant_oh_o[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i && grant_valid_o) begin
            ptr_d = (grant_idx_o == SELW'(NUM_REQS - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vx_lsu_req_arb.sv
// -----------------------------------------------------------------------------
// vx_lsu_req_arb
// Merges NUM_REQS issue channels into one LSU request stream: round-robin
// arbitration, 2-entry skid buffer, strict in-order head gating on the count of
// outstanding non-fence requests (fences wait for zero outstanding).
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   req_valid_in/data_in/fence_in, req_ready_in : per-channel input handshake
//   req_valid_out/data_out/fence_out/sel_out, req_ready_out : LSU side
//   rsp_done_in                : one non-fence request completed
//   pending_count              : outstanding non-fence requests
// Optional (macro VX_LSU_REQ_ARB_PERF_EN):
//   perf_fence_stall, perf_pend_stall : saturating 32-bit stall-cycle counters
// -----------------------------------------------------------------------------
module vx_lsu_req_arb
    import vx_lsu_pkg::*;
#(
    parameter int unsigned NUM_REQS    = 4,
    parameter int unsigned DATAW       = 128,
    parameter int unsigned MAX_PENDING = 16,
    localparam int unsigned SELW       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int unsigned CNTW       = $clog2(MAX_PENDING + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       req_valid_in,
    input  logic [NUM_REQS*DATAW-1:0] req_data_in,
    input  logic [NUM_REQS-1:0]       req_fence_in,
    output logic [NUM_REQS-1:0]       req_ready_in,
    output logic                      req_valid_out,
    output logic [DATAW-1:0]          req_data_out,
    output logic                      req_fence_out,
    output logic [SELW-1:0]           req_sel_out,
    input  logic                      req_ready_out,
    input  logic                      rsp_done_in,
    output logic [CNTW-1:0]           pending_count
`ifdef VX_LSU_REQ_ARB_PERF_EN
    ,
    output logic [31:0]               perf_fence_stall,
    output logic [31:0]               perf_pend_stall
`endif
);

    logic                  grant_valid;
    logic [SELW-1:0]       grant_idx;
    logic [NUM_REQS-1:0]   grant_oh;

    lsu_skid_entry_t       buf_q [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [CNTW-1:0]       pend_q, pend_d;

    lsu_skid_entry_t       in_entry;
    lsu_skid_entry_t       head;
    logic                  full, empty, push, pop, head_ok, inc, dec;
    logic                  unused_sel_hi;

    // Grant depends only on buffer occupancy, never on req_ready_out.
    assign full = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign push = grant_valid & ~full & ~reset;

    vx_rr_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_arb (
        .clk_i         (clk),
        .rst_i         (reset),
        .req_i         (req_valid_in),
        .accept_i      (push),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx),
        .grant_oh_o    (grant_oh)
    );

    assign req_ready_in = grant_oh & {NUM_REQS{~full & ~reset}};

    always_comb begin
        in_entry       = '0;
        in_entry.req   = req_data_in[grant_idx*DATAW +: DATAW];
        in_entry.fence = req_fence_in[grant_idx];
        in_entry.sel   = LSU_SEL_MAXW'(grant_idx);
    end

    assign head = buf_q[rd_ptr_q];
    assign head_ok = head.fence ? (pend_q == '0) : (pend_q < CNTW'(MAX_PENDING));

    assign req_valid_out = ~empty & head_ok;
    assign req_data_out = empty ? '0 : head.req;
    assign req_fence_out = ~empty & head.fence;
    assign req_sel_out = empty ? '0 : head.sel[SELW-1:0];
    assign unused_sel_hi = ^head.sel;
    assign pending_count = pend_q;

    assign pop = req_valid_out & req_ready_out;
    assign inc = pop & ~head.fence;
    assign dec = rsp_done_in;

    always_comb begin
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Same-cycle inc/dec cancel; a dec with nothing outstanding is dropped.
    always_comb begin
        pend_d = pend_q;
        if (inc && !dec) begin
            pend_d = pend_q + 1'b1;
        end else if (!inc && dec && (pend_q != '0)) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= '0;
            pend_q   <= '0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= in_entry;
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
        end
    end

    a_no_dec_underflow: assert property (
        @(posedge clk) disable iff (reset) !(dec && !inc && (pend_q == '0))
    );

`ifdef VX_LSU_REQ_ARB_PERF_EN
    logic [31:0] perf_fence_q, perf_fence_d;
    logic [31:0] perf_pend_q, perf_pend_d;
    logic        fence_stall, pend_stall;

    assign fence_stall = ~empty & head.fence & (pend_q != '0);
    assign pend_stall = ~empty & ~head.fence & (pend_q == CNTW'(MAX_PENDING));

    always_comb begin
        perf_fence_d = perf_fence_q;
        perf_pend_d  = perf_pend_q;
        if (fence_stall && (perf_fence_q != '1)) perf_fence_d = perf_fence_q + 32'd1;
        if (pend_stall && (perf_pend_q != '1)) perf_pend_d = perf_pend_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fence_q <= '0;
            perf_pend_q  <= '0;
        end else begin
            perf_fence_q <= perf_fence_d;
            perf_pend_q  <= perf_pend_d;
        end
    end

    assign perf_fence_stall = perf_fence_q;
    assign perf_pend_stall = perf_pend_q;
`endif

endmodule
